bcd_display_scanner: RTL and testbench

- Parametrised successor to the calculator's fixed two-digit display decoder.
- Takes a WIDTH-bit binary result plus the Zero/Overflow flags on a Load strobe. Converts it sequentially to DIGITS BCD digits using shift-add-3 (double dabble), one shift per clock.
- Commits the converted digits atomically, then drives a time-multiplexed 7-segment bank (one shared segment bus, one-hot digit select).
- Sits between the ALU/controller and the board display pins.

---
 rtl/bcd_display_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_bcd_display_scanner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: sequential binary-to-BCD conversion (double dabble,
// one shift per clock) feeding a time-multiplexed 7-segment display bank.
// Optional feature macro: BCD_DISPLAY_LEADING_BLANK_EN (blank leading zeros).
module bcd_display_scanner #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Value,
    input  logic              Load,
    input  logic              Zero,
    input  logic              Overflow,
    output logic              Busy,
    output logic              Ready,
    output logic [7:0]        Segments,
    output logic [DIGITS-1:0] DigitSel
);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Decimal digits needed to hold 2^w-1
    function automatic int unsigned dec_digits(input int unsigned w);
        int unsigned v;
        int unsigned n;
        v = (32'd1 << w) - 32'd1;
        n = 0;
        while (v != 0) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int unsigned POW10 = pow10(DIGITS);
    localparam int unsigned NEED  = dec_digits(WIDTH);
    localparam int unsigned NDIG  = (NEED > DIGITS) ? NEED : DIGITS;
    localparam int unsigned BCD_W = 4 * NDIG;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ZERO  = 8'h3F;

`ifdef BCD_DISPLAY_LEADING_BLANK_EN
    localparam bit LEAD_BLANK = 1'b1;
`else
    localparam bit LEAD_BLANK = 1'b0;
`endif

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                   state_q, state_d;
    logic                     busy_d, ready_d, commit_en;
    logic [BCD_W-1:0]         bcd_q, bcd_adj;
    logic [WIDTH-1:0]         bin_q, value_q;
    logic                     zero_q, ovf_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [DIGITS-1:0][7:0]   codes_q, codes_d;
    logic [PRE_W-1:0]         presc_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     range_ovf, lead, blank;
    logic [3:0]               digit;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Load) state_d = CONVERT;
            CONVERT: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode (next values of the registered status flags)
    always_comb begin
        busy_d    = (state_d != IDLE);
        ready_d   = (state_q == COMMIT);
        commit_en = (state_q == COMMIT);
    end

    // Registered status outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Busy  <= 1'b0;
            Ready <= 1'b0;
        end else begin
            Busy  <= busy_d;
            Ready <= ready_d;
        end
    end

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Capture on load, then one shift of {bcd,bin} per clock while converting
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bcd_q   <= '0;
            bin_q   <= '0;
            value_q <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Load) begin
                        value_q <= Value;
                        bin_q   <= Value;
                        zero_q  <= Zero;
                        ovf_q   <= Overflow;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CONVERT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
                    bin_q <= {bin_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Display codes to commit: dash > forced zero > converted digits
    always_comb begin
        codes_d   = '0;
        range_ovf = ovf_q || (32'(value_q) >= POW10);
        lead      = 1'b1;
        blank     = 1'b0;
        digit     = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            digit = bcd_q[4*(DIGITS-1-k) +: 4];
            if (digit != 4'd0) lead = 1'b0;
            blank = LEAD_BLANK && (k != DIGITS - 1);
            if (range_ovf)   codes_d[DIGITS-1-k] = SEG_DASH;
            else if (zero_q) codes_d[DIGITS-1-k] = blank ? SEG_BLANK : SEG_ZERO;
            else             codes_d[DIGITS-1-k] = (blank && lead) ? SEG_BLANK : seg_code(digit);
        end
    end

    // Committed codes, all digits written in the same edge
    always_ff @(posedge Clock) begin
        if (Reset)          codes_q <= {DIGITS{SEG_ZERO}};
        else if (commit_en) codes_q <= codes_d;
    end

    // Free-running scan prescaler and digit index
    always_ff @(posedge Clock) begin
        if (Reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Segment bus and digit select registered together from the current index
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Segments <= SEG_ZERO;
            DigitSel <= DIGITS'(1);
        end else begin
            Segments <= codes_q[idx_q];
            DigitSel <= DIGITS'(1) << idx_q;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Testbench for bcd_display_scanner: reference model + scoreboard + monitor.
// Honours BCD_DISPLAY_LEADING_BLANK_EN the same way as the design.
module tb_bcd_display_scanner;

    localparam int unsigned W  = 10;
    localparam int unsigned D  = 3;
    localparam int unsigned SD = 4;

`ifdef BCD_DISPLAY_LEADING_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [7:0] SEG_TAB [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                            8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    logic         clk;
    logic         rst;
    logic [W-1:0] value;
    logic         load, zero, ovf;
    logic         busy, ready;
    logic [7:0]   seg;
    logic [D-1:0] sel;

    bcd_display_scanner #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
        .Clock(clk), .Reset(rst), .Value(value), .Load(load), .Zero(zero),
        .Overflow(ovf), .Busy(busy), .Ready(ready), .Segments(seg), .DigitSel(sel)
    );

    int          checks;
    int          errors;
    int unsigned edges;
    int          busy_left;
    bit          ready_exp;
    bit          started;
    logic [D-1:0][7:0] exp_q[$];
    logic [D-1:0][7:0] disp_cur;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected committed codes computed directly from decimal arithmetic
    function automatic logic [D-1:0][7:0] model_codes(input int unsigned v, input bit z, input bit o);
        logic [D-1:0][7:0] r;
        int unsigned limit;
        int unsigned p;
        limit = 1;
        for (int i = 0; i < int'(D); i++) limit = limit * 10;
        p = 1;
        for (int i = 0; i < int'(D); i++) begin
            if (o || v >= limit)                 r[i] = 8'h40;
            else if (z)                          r[i] = (BLANK_EN && i > 0) ? 8'h00 : 8'h3F;
            else if (BLANK_EN && i > 0 && v < p) r[i] = 8'h00;
            else                                 r[i] = SEG_TAB[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks accepted loads and the busy window per edge
    initial begin
        edges = 0; busy_left = 0; ready_exp = 1'b0; started = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                edges = 0; busy_left = 0; ready_exp = 1'b0; started = 1'b1;
                exp_q.delete();
            end else begin
                edges++;
                ready_exp = 1'b0;
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) ready_exp = 1'b1;
                end else if (load) begin
                    busy_left = W + 1;
                    exp_q.push_back(model_codes(32'(value), zero, ovf));
                end
            end
        end
    end

    // Monitor: checks status, scan position and displayed codes every cycle
    initial begin
        int unsigned idx;
        forever begin
            @(negedge clk);
            if (started) begin
                if (edges == 0) disp_cur = {D{8'h3F}};
                idx = (edges == 0) ? 0 : ((edges - 1) / SD) % D;
                check("busy", 32'(busy), 32'(busy_left > 0));
                check("ready", 32'(ready), 32'(ready_exp));
                check("digit_sel", 32'(sel), 32'(1) << idx);
                check("segments", 32'(seg), 32'(disp_cur[idx]));
                if (ready) begin
                    check("pending_at_ready", 32'(exp_q.size()), 1);
                    if (exp_q.size() > 0) disp_cur = exp_q.pop_front();
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int unsigned v, input bit z, input bit o);
        @(posedge clk); #1;
        load = 1'b1; value = W'(v); zero = z; ovf = o;
        @(posedge clk); #1;
        load = 1'b0; zero = 1'b0; ovf = 1'b0; value = W'($urandom);
    endtask

    localparam int SETTLE = W + 3 + D * SD;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; load = 1'b0; zero = 1'b0; ovf = 1'b0; value = '0;
        idle(3);
        rst = 1'b0;
        idle(3 * D * SD);

        do_load(157, 0, 0);  idle(SETTLE);
        do_load(5, 0, 1);    idle(SETTLE);
        do_load(999, 0, 0);  idle(SETTLE);
        do_load(1000, 0, 0); idle(SETTLE);
        do_load(1023, 0, 0); idle(SETTLE);
        do_load(0, 0, 0);    idle(SETTLE);
        do_load(42, 1, 0);   idle(SETTLE);
        do_load(90, 0, 0);   idle(SETTLE);

        // Load during busy must be ignored
        do_load(157, 0, 0); idle(3);
        do_load(99, 0, 0);  idle(SETTLE);

        // Reset mid-conversion discards it, next load completes
        do_load(200, 0, 0); idle(4);
        rst = 1'b1; idle(1); rst = 1'b0;
        idle(3);
        do_load(7, 0, 0); idle(SETTLE);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1; idle(1); rst = 1'b0;
            end
            do_load($urandom_range(0, 1023), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            idle(int'($urandom_range(0, W + 4)));
        end

        idle(SETTLE);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
